// File: rtl/inv_cipher_round.sv
// -----------------------------------------------------------------------------
// inv_cipher_round
//
// One AES inverse-cipher round for the decryption datapath. Each accepted
// 128-bit state goes through InvShiftRows, InvSubBytes and AddRoundKey, then
// InvMixColumns unless the round was flagged as the last one. Byte k of a
// state sits in bits [8k+7:8k]; state element s[r][c] is byte r+4c.
//
// PIPE_STAGES = 2: stage 1 holds InvShiftRows+InvSubBytes, the output stage
//                  holds AddRoundKey+InvMixColumns.
// PIPE_STAGES = 1: the whole round lands in the output register.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   i_Valid  upstream state/key/last valid
//   o_Ready  block can accept this cycle (combinational from i_Ready)
//   i_Data   input state
//   i_Key    round key, captured with the state
//   i_Last   1 = final round, skip InvMixColumns
//   o_Valid  o_Data holds a result (registered)
//   i_Ready  downstream accepts o_Data
//   o_Data   round output state (registered, resets to 0)
// -----------------------------------------------------------------------------
module inv_cipher_round #(
    parameter int PIPE_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_Valid,
    output logic         o_Ready,
    input  logic [127:0] i_Data,
    input  logic [127:0] i_Key,
    input  logic         i_Last,
    output logic         o_Valid,
    input  logic         i_Ready,
    output logic [127:0] o_Data
);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (shift-and-add).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] acc;
        prod = 8'h00;
        acc  = a;
        for (int i = 0; i < 8; i++) begin
            prod = prod ^ (acc & {8{b[i]}});
            acc  = {acc[6:0], 1'b0} ^ (8'h1b & {8{acc[7]}});
        end
        return prod;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] pw;
        logic [7:0] res;
        pw  = a;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            res = gf_mul(res, pw);
        end
        return res;
    endfunction

    // Inverse S-box: undo the affine transform, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Row r rotates right by r columns: out[r][c] = in[r][(c-r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] st);
        logic [127:0] res;
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[8*(r+4*c) +: 8] = st[8*(r+4*((c-r+4)%4)) +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] st);
        logic [127:0] res;
        res = 128'h0;
        for (int k = 0; k < 16; k++) begin
            res[8*k +: 8] = inv_sbox(st[8*k +: 8]);
        end
        return res;
    endfunction

    // Column-wise multiply by the circulant {0e,0b,0d,09}.
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] st);
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = st[8*(4*c+0) +: 8];
            a1 = st[8*(4*c+1) +: 8];
            a2 = st[8*(4*c+2) +: 8];
            a3 = st[8*(4*c+3) +: 8];
            res[8*(4*c+0) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            res[8*(4*c+1) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            res[8*(4*c+2) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            res[8*(4*c+3) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return res;
    endfunction

    logic         out_valid_r;
    logic [127:0] out_data_r;
    logic         out_load_s;
    logic         ready_s;

    // Output stage may load when empty or when its result leaves this cycle.
    assign out_load_s = !out_valid_r || i_Ready;
    assign o_Valid    = out_valid_r;
    assign o_Data     = out_data_r;
    assign o_Ready    = ready_s;

    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
            logic         s1_valid_r;
            logic [127:0] s1_state_r;
            logic [127:0] s1_key_r;
            logic         s1_last_r;
            logic [127:0] front_s;
            logic [127:0] ark_s;
            logic [127:0] back_s;

            // Stage 1 advances whenever the output stage can take its contents.
            assign ready_s = !s1_valid_r || out_load_s;

            // Front half of the round: byte permutation then substitution.
            always_comb begin
                front_s = inv_sub_bytes(inv_shift_rows(i_Data));
            end

            // Back half: key addition, column mix unless this is the last round.
            always_comb begin
                ark_s = s1_state_r ^ s1_key_r;
                if (s1_last_r) begin
                    back_s = ark_s;
                end else begin
                    back_s = inv_mix_columns(ark_s);
                end
            end

            // Stage 1 register; key and last flag travel alongside the state.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_r <= 1'b0;
                    s1_state_r <= 128'h0;
                    s1_key_r   <= 128'h0;
                    s1_last_r  <= 1'b0;
                end else if (ready_s) begin
                    s1_valid_r <= i_Valid;
                    if (i_Valid) begin
                        s1_state_r <= front_s;
                        s1_key_r   <= i_Key;
                        s1_last_r  <= i_Last;
                    end
                end
            end

            // Output register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_r <= 1'b0;
                    out_data_r  <= 128'h0;
                end else if (out_load_s) begin
                    out_valid_r <= s1_valid_r;
                    if (s1_valid_r) begin
                        out_data_r <= back_s;
                    end
                end
            end
        end else if (PIPE_STAGES == 1) begin : g_one_stage
            logic [127:0] ark_s;
            logic [127:0] round_s;

            assign ready_s = out_load_s;

            // Full round in one combinational cloud.
            always_comb begin
                ark_s = inv_sub_bytes(inv_shift_rows(i_Data)) ^ i_Key;
                if (i_Last) begin
                    round_s = ark_s;
                end else begin
                    round_s = inv_mix_columns(ark_s);
                end
            end

            // Output register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_r <= 1'b0;
                    out_data_r  <= 128'h0;
                end else if (out_load_s) begin
                    out_valid_r <= i_Valid;
                    if (i_Valid) begin
                        out_data_r <= round_s;
                    end
                end
            end
        end else begin : g_bad_pipe_stages
            $error("inv_cipher_round: PIPE_STAGES must be 1 or 2");
        end
    endgenerate

endmodule
